// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, writeback record and lane-qualify helper for the writeback arbiter.
package writeback_arbiter_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_rec_t;

  // A lane result only reaches the register file if it is a real GPR write (not r0).
  function automatic logic lane_live(input logic valid, input logic we,
                                     input logic [GPR_ADDR_W-1:0] rd);
    return valid & we & (rd != '0);
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// 1-push / 2-pop circular FIFO for long-latency results; exposes head and head+1.
module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_rec_t          push_rec,
  input  logic             pop0,
  input  logic             pop1,
  output wb_rec_t          head_c,
  output wb_rec_t          head_next_c,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c,
  output logic             ready
);

  wb_rec_t          mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] n_pop;

  // pop1 is only ever raised together with pop0
  always_comb begin
    n_pop       = CNT_W'(pop0) + CNT_W'(pop1);
    count_nxt_c = count + CNT_W'(push) - n_pop;
  end

  // Ready comes from the registered count, so a full FIFO never pushes and pops together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ready <= 1'b1;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      rptr  <= rptr + PTR_W'(n_pop);
      count <= count_nxt_c;
      ready <= (count_nxt_c != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_rec;
  end

  assign head_c      = mem[rptr];
  assign head_next_c = mem[rptr + PTR_W'(1)];

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: two in-order EX2 lanes plus a queued long-latency
// unit share two registered write ports; port 1 always carries the younger value.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned LU_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eu0_valid,
  input  logic        eu0_we,
  input  logic [4:0]  eu0_rd,
  input  logic [31:0] eu0_data,
  input  logic        eu1_valid,
  input  logic        eu1_we,
  input  logic [4:0]  eu1_rd,
  input  logic [31:0] eu1_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        write_en_0,
  output logic [4:0]  write_addr_0,
  output logic [31:0] write_data_0,
  output logic        write_en_1,
  output logic [4:0]  write_addr_1,
  output logic [31:0] write_data_1,
  output logic        lu_empty
);

  localparam int unsigned CNT_W = $clog2(LU_DEPTH + 1);

  logic             live0;
  logic             live1;
  logic             push;
  logic             pop0;
  logic             pop1;
  logic             have1;
  logic             have2;
  wb_rec_t          push_rec;
  wb_rec_t          head;
  wb_rec_t          head_next;
  logic [CNT_W-1:0] lu_count;
  logic [CNT_W-1:0] lu_count_nxt;

  wb_result_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_rec    (push_rec),
    .pop0        (pop0),
    .pop1        (pop1),
    .head_c      (head),
    .head_next_c (head_next),
    .count       (lu_count),
    .count_nxt_c (lu_count_nxt),
    .ready       (lu_ready)
  );

  // Port allocation: lanes own their ports; the FIFO fills whatever is left.
  always_comb begin
    live0    = lane_live(eu0_valid, eu0_we, eu0_rd);
    live1    = lane_live(eu1_valid, eu1_we, eu1_rd);
    have1    = (lu_count != '0);
    have2    = (lu_count >= CNT_W'(2));
    push     = lu_valid & lu_ready & (lu_rd != '0);
    push_rec = '{rd: lu_rd, data: lu_data};
    pop0     = 1'b0;
    pop1     = 1'b0;
    case ({live0, live1})
      2'b00: begin
        pop0 = have1;
        pop1 = have2;
      end
      // head would land on port 1 and outrank eu0; hold it if it targets the same GPR
      2'b10:   pop0 = have1 & (head.rd != eu0_rd);
      2'b01:   pop0 = have1 & (head.rd != eu1_rd);
      default: ;
    endcase
  end

  // Registered write ports; address/data hold while a port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_0   <= 1'b0;
      write_addr_0 <= '0;
      write_data_0 <= '0;
      write_en_1   <= 1'b0;
      write_addr_1 <= '0;
      write_data_1 <= '0;
      lu_empty     <= 1'b1;
    end else begin
      write_en_0 <= live0 | pop0;
      if (live0) begin
        write_addr_0 <= eu0_rd;
        write_data_0 <= eu0_data;
      end else if (pop0) begin
        write_addr_0 <= head.rd;
        write_data_0 <= head.data;
      end

      write_en_1 <= live1 | pop1 | (pop0 & live0);
      if (live1) begin
        write_addr_1 <= eu1_rd;
        write_data_1 <= eu1_data;
      end else if (pop1) begin
        write_addr_1 <= head_next.rd;
        write_data_1 <= head_next.data;
      end else if (pop0 & live0) begin
        write_addr_1 <= head.rd;
        write_data_1 <= head.data;
      end

      lu_empty <= (lu_count_nxt == '0) & ~pop0;
    end
  end

endmodule
